id_issue: RTL and testbench

ID_ISSUE -- requirements
Module: id_issue

---
 rtl/id_issue.sv | 92 +++++++++
 tb/tb_id_issue.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/id_issue.sv
// id_issue: decode-to-execute issue register with a per-register pending-write scoreboard.
// Stalls on RAW/WAW hazards, accepts same-cycle writeback bypass on sources, handles flush.
module id_issue #(
    parameter int WORD = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [4:0]      rn,
    input  logic [4:0]      rm,
    input  logic [4:0]      rd,
    input  logic            use_rn,
    input  logic            use_rm,
    input  logic            reg_write,
    input  logic [WORD-1:0] read_data1,
    input  logic [WORD-1:0] read_data2,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [WORD-1:0] ex_data1,
    output logic [WORD-1:0] ex_data2,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            flush,
    output logic [NREG-1:0] pending,
    output logic [15:0]     stall_cnt
);
    localparam logic [4:0] XZR = 5'd31;

    logic            ex_valid_q, ex_valid_d;
    logic [WORD-1:0] ex_data1_q, ex_data1_d, ex_data2_q, ex_data2_d;
    logic [4:0]      ex_rd_q, ex_rd_d;
    logic            ex_rw_q, ex_rw_d;
    logic [NREG-1:0] pend_q, pend_d;
    logic [15:0]     stall_q, stall_d;
    logic            fwd_rn, fwd_rm, hazard, issue;

    always_comb begin
        // A writeback in the issue cycle is already visible in read_data, so it bypasses the source check
        fwd_rn     = wb_valid && wb_rd == rn;
        fwd_rm     = wb_valid && wb_rd == rm;
        hazard     = (use_rn && pend_q[rn] && !fwd_rn) || (use_rm && pend_q[rm] && !fwd_rm) ||
                     (reg_write && pend_q[rd]);
        id_ready   = !hazard && !flush && (!ex_valid_q || ex_ready);
        issue      = id_valid && id_ready;
        ex_valid_d = issue ? 1'b1 : (flush || ex_ready) ? 1'b0 : ex_valid_q;
        ex_data1_d = issue ? read_data1 : ex_data1_q;
        ex_data2_d = issue ? read_data2 : ex_data2_q;
        ex_rd_d    = issue ? rd : ex_rd_q;
        ex_rw_d    = issue ? reg_write : ex_rw_q;
        pend_d     = pend_q;
        if (wb_valid)
            pend_d[wb_rd] = 1'b0;
        if (flush && ex_valid_q && ex_rw_q)
            pend_d[ex_rd_q] = 1'b0;
        // Set last so a new producer wins over a same-edge clear; XZR is never marked
        if (issue && reg_write && rd != XZR)
            pend_d[rd] = 1'b1;
        stall_d    = (id_valid && !id_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_data1_q <= '0;
            ex_data2_q <= '0;
            ex_rd_q    <= '0;
            ex_rw_q    <= 1'b0;
            pend_q     <= '0;
            stall_q    <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_data1_q <= ex_data1_d;
            ex_data2_q <= ex_data2_d;
            ex_rd_q    <= ex_rd_d;
            ex_rw_q    <= ex_rw_d;
            pend_q     <= pend_d;
            stall_q    <= stall_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_data1     = ex_data1_q;
    assign ex_data2     = ex_data2_q;
    assign ex_rd        = ex_rd_q;
    assign ex_reg_write = ex_rw_q;
    assign pending      = pend_q;
    assign stall_cnt    = stall_q;
endmodule

// File: tb/tb_id_issue.sv
// tb_id_issue: directed scenario tests for id_issue with hand-computed expectations.
module tb_id_issue;
    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_ready;
    logic [4:0]  rn, rm, rd;
    logic        use_rn, use_rm, reg_write;
    logic [63:0] read_data1, read_data2;
    logic        ex_valid, ex_ready;
    logic [63:0] ex_data1, ex_data2;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] pending;
    logic [15:0] stall_cnt;
    int          n_checks = 0;
    int          n_fail = 0;

    id_issue #(.WORD(64), .NREG(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
        .rn(rn), .rm(rm), .rd(rd), .use_rn(use_rn), .use_rm(use_rm), .reg_write(reg_write),
        .read_data1(read_data1), .read_data2(read_data2), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .pending(pending), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle(input logic rdy);
        id_valid = 0; rn = 0; rm = 0; rd = 0; use_rn = 0; use_rm = 0; reg_write = 0;
        read_data1 = 0; read_data2 = 0; ex_ready = rdy; wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic edge_sample;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1;
        idle(1'b0);
        #2;
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
        n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending got=%h exp=0", pending); end
        n_checks++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall got=%h exp=0", stall_cnt); end
        n_checks++; if (ex_data1 !== 64'h0 || ex_rd !== 5'd0 || ex_reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_ex_fields got=%h/%0d/%b exp=0/0/0", ex_data1, ex_rd, ex_reg_write); end
        n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL reset_id_ready got=%b exp=1", id_ready); end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_issue;
        @(negedge clk);
        idle(1'b1);
        id_valid = 1; rd = 9; reg_write = 1; rn = 1; use_rn = 1; read_data1 = 64'hAA; read_data2 = 64'hBB;
        #1;
        n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL issue_ready got=%b exp=1", id_ready); end
        edge_sample;
        n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL issue_ex_valid got=%b exp=1", ex_valid); end
        n_checks++; if (ex_rd !== 5'd9 || ex_reg_write !== 1'b1) begin n_fail++; $display("FAIL issue_ex_rd got=%0d/%b exp=9/1", ex_rd, ex_reg_write); end
        n_checks++; if (ex_data1 !== 64'hAA || ex_data2 !== 64'hBB) begin n_fail++; $display("FAIL issue_ex_data got=%h/%h exp=aa/bb", ex_data1, ex_data2); end
        n_checks++; if (pending !== 32'h200) begin n_fail++; $display("FAIL issue_pending got=%h exp=00000200", pending); end
        @(negedge clk);
        idle(1'b1);
        edge_sample;
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL consume_ex_valid got=%b exp=0", ex_valid); end
        n_checks++; if (pending !== 32'h200) begin n_fail++; $display("FAIL consume_pending got=%h exp=00000200", pending); end
    endtask

    task automatic test_stall_forward;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            idle(1'b1);
            id_valid = 1; rn = 9; use_rn = 1; rd = 3; reg_write = 1; read_data1 = 64'd256;
            #1;
            n_checks++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready got=%b exp=0", id_ready); end
            edge_sample;
            n_checks++; if (stall_cnt !== 16'(i)) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, i); end
            n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL stall_ex_valid got=%b exp=0", ex_valid); end
        end
        @(negedge clk);
        wb_valid = 1; wb_rd = 9;
        #1;
        n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL fwd_ready got=%b exp=1", id_ready); end
        edge_sample;
        n_checks++; if (ex_valid !== 1'b1 || ex_data1 !== 64'd256 || ex_rd !== 5'd3) begin n_fail++; $display("FAIL fwd_issue got=%b/%0d/%0d exp=1/256/3", ex_valid, ex_data1, ex_rd); end
        n_checks++; if (pending !== 32'h8) begin n_fail++; $display("FAIL fwd_pending got=%h exp=00000008", pending); end
        n_checks++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL fwd_stall got=%0d exp=2", stall_cnt); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        idle(1'b0);
        id_valid = 1; rd = 4; reg_write = 1; read_data1 = 64'd77;
        #1;
        n_checks++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready got=%b exp=0", id_ready); end
        edge_sample;
        n_checks++; if (ex_valid !== 1'b1 || ex_data1 !== 64'd256 || ex_rd !== 5'd3) begin n_fail++; $display("FAIL hold_stable got=%b/%0d/%0d exp=1/256/3", ex_valid, ex_data1, ex_rd); end
        n_checks++; if (stall_cnt !== 16'd3 || pending !== 32'h8) begin n_fail++; $display("FAIL hold_state got=%0d/%h exp=3/00000008", stall_cnt, pending); end
        @(negedge clk);
        ex_ready = 1;
        #1;
        n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got=%b exp=1", id_ready); end
        edge_sample;
        n_checks++; if (ex_valid !== 1'b1 || ex_data1 !== 64'd77 || ex_rd !== 5'd4) begin n_fail++; $display("FAIL b2b_reload got=%b/%0d/%0d exp=1/77/4", ex_valid, ex_data1, ex_rd); end
        n_checks++; if (pending !== 32'h18) begin n_fail++; $display("FAIL b2b_pending got=%h exp=00000018", pending); end
        @(negedge clk);
        idle(1'b1);
        wb_valid = 1; wb_rd = 3;
        edge_sample;
        n_checks++; if (ex_valid !== 1'b0 || pending !== 32'h10) begin n_fail++; $display("FAIL wb3 got=%b/%h exp=0/00000010", ex_valid, pending); end
        @(negedge clk);
        wb_rd = 4;
        edge_sample;
        n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL wb4 got=%h exp=0", pending); end
    endtask

    task automatic test_xzr;
        @(negedge clk);
        idle(1'b1);
        id_valid = 1; rd = 31; reg_write = 1;
        edge_sample;
        n_checks++; if (pending !== 32'h0 || ex_valid !== 1'b1 || ex_rd !== 5'd31) begin n_fail++; $display("FAIL xzr_write got=%h/%b/%0d exp=0/1/31", pending, ex_valid, ex_rd); end
        @(negedge clk);
        idle(1'b1);
        id_valid = 1; rn = 31; use_rn = 1; wb_valid = 1; wb_rd = 31;
        #1;
        n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL xzr_read_ready got=%b exp=1", id_ready); end
        edge_sample;
        n_checks++; if (pending !== 32'h0 || stall_cnt !== 16'd3) begin n_fail++; $display("FAIL xzr_state got=%h/%0d exp=0/3", pending, stall_cnt); end
        @(negedge clk);
        idle(1'b1);
        edge_sample;
    endtask

    task automatic test_flush;
        @(negedge clk);
        idle(1'b0);
        id_valid = 1; rd = 5; reg_write = 1;
        edge_sample;
        n_checks++; if (pending !== 32'h20 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL flush_setup got=%h/%b exp=00000020/1", pending, ex_valid); end
        @(negedge clk);
        idle(1'b1);
        flush = 1; id_valid = 1; rd = 6; reg_write = 1;
        #1;
        n_checks++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got=%b exp=0", id_ready); end
        edge_sample;
        n_checks++; if (ex_valid !== 1'b0 || pending !== 32'h0) begin n_fail++; $display("FAIL flush_clear got=%b/%h exp=0/0", ex_valid, pending); end
        n_checks++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL flush_stall got=%0d exp=4", stall_cnt); end
        @(negedge clk);
        idle(1'b1);
        id_valid = 1; rd = 5; reg_write = 1; wb_valid = 1; wb_rd = 5;
        edge_sample;
        n_checks++; if (pending !== 32'h20 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL set_wins got=%h/%b exp=00000020/1", pending, ex_valid); end
        @(negedge clk);
        idle(1'b0);
        flush = 1; wb_valid = 1; wb_rd = 5;
        edge_sample;
        n_checks++; if (pending !== 32'h0 || ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_wb got=%h/%b exp=0/0", pending, ex_valid); end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        idle(1'b1);
        id_valid = 1; rd = 9; reg_write = 1; read_data1 = 64'h1234;
        edge_sample;
        @(negedge clk);
        rd = 10;
        edge_sample;
        n_checks++; if (pending !== 32'h600 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL areset_setup got=%h/%b exp=00000600/1", pending, ex_valid); end
        @(negedge clk);
        idle(1'b0);
        #2;
        reset = 1;
        #1;
        n_checks++; if (pending !== 32'h0 || ex_valid !== 1'b0) begin n_fail++; $display("FAIL areset_clear got=%h/%b exp=0/0", pending, ex_valid); end
        n_checks++; if (ex_rd !== 5'd0 || ex_data1 !== 64'h0 || stall_cnt !== 16'd0) begin n_fail++; $display("FAIL areset_fields got=%0d/%h/%0d exp=0/0/0", ex_rd, ex_data1, stall_cnt); end
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        test_reset;
        test_issue;
        test_stall_forward;
        test_back_to_back;
        test_xzr;
        test_flush;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
